mult_share_arbiter: RTL
=======================

Name: mult_share_arbiter

Overview:
- Shares one radix-4 Booth 32x32 signed multiplier among NUM_REQ requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The block arbitrates round-robin, issues one operation at a time to the multiplier, tracks its busy/ready sequence, captures the 64-bit product and returns it to the granted requester.
- It sits between client datapaths and the multiplier instance, on the same clock and reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, grant index width, equal to clog2(NUM_REQ).
- TIMEOUT, 32, maximum cycles allowed in WAIT before the operation is aborted with an error.

Ports:
- clk  in  1  single clock, rising edge.
- sync_rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*32  packed operand A, requester i at [32i+31:32i].
- req_b  in  NUM_REQ*32  packed operand B, same packing.
- rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_r  out  64  signed product, shared by all requesters.
- rsp_err  out  1  qualifies rsp_valid; 1 = operation timed out and rsp_r = 0.
- mul_valid  out  1  to multiplier valid.
- mul_a  out  32  to multiplier A.
- mul_b  out  32  to multiplier B.
- mul_r  in  64  from multiplier R.
- mul_ready  in  1  from multiplier ready.
- busy  out  1  high in any state except IDLE.
- grant_id  out  ID_W  index of the current owner; holds its last value while IDLE.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low.
  - While sync_rst_n = 0 at a clock edge: state goes to IDLE; rr_ptr = 0; all outputs are 0 (req_ready, rsp_valid, rsp_r, rsp_err, mul_valid, mul_a, mul_b, busy, grant_id); op latches and the timeout counter clear.
  - The multiplier shares this reset through an inverter at top level.
  - Reset mid-operation abandons the operation; no response is produced.
- State machine:
  - IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i], searching from rr_ptr upward with wrap.
  - If a winner exists: req_ready[winner] = 1 combinationally; latch a, b and id; rr_ptr <= winner+1 mod NUM_REQ; next state is ISSUE.
  - If no request is valid: remain in IDLE and leave rr_ptr unchanged.
- ISSUE:
  - mul_valid = 1; mul_a and mul_b driven from the latches.
  - Advance to WAIT on the edge where mul_ready = 1.
  - mul_valid is never high outside ISSUE.
  - mul_a and mul_b hold their values outside ISSUE.
- WAIT:
  - Clear seen_busy on entry.
  - Set seen_busy when mul_ready = 0.
  - When seen_busy = 1 and mul_ready = 1: capture mul_r into rsp_r, rsp_err <= 0, next state is RESP.
  - The timeout counter increments every WAIT cycle. If it reaches TIMEOUT first: rsp_r <= 0, rsp_err <= 1, next state is RESP.
- RESP:
  - rsp_valid[id] = 1 while rsp_r and rsp_err are held stable.
  - Advance to IDLE on rsp_ready[id] = 1.
  - rsp_ready for other indices is ignored.
- Handshake rules:
  - Each requester keeps at most one operation outstanding. A requester may assert req_valid while its response is pending, but it is not granted until the block returns to IDLE.
  - A response handshake and a new request in the same cycle: the request waits for IDLE in the next cycle, so there is exactly one IDLE cycle between operations.
- Latency with the nominal multiplier:
  - Accept in cycle 0, ISSUE in cycle 1, multiplier busy in cycles 2..17, product captured at the end of cycle 18.
  - rsp_valid first high in cycle 19.
  - Sustained throughput is one operation per 20 cycles when rsp_ready is held high.
- Arithmetic:
  - The block passes operands and result unchanged.
  - Signed two's-complement interpretation belongs to the multiplier.
- Assertions for the bench:
  - req_ready and rsp_valid are each onehot0.
  - mul_valid & ~mul_ready never persists beyond ISSUE.

Decomposition:
- Shared package mult_share_pkg:
  - State enum {IDLE, ISSUE, WAIT, RESP}.
  - Constants MUL_W = 32 and PROD_W = 64.
  - Function rr_pick(valid_vec, ptr), returning the one-hot winner.
- Sub-module rr_arbiter: combinational round-robin pick from req_valid and rr_ptr, producing a one-hot grant and its index. rr_ptr is held in the parent.
- The timeout counter and FSM stay in the top module.

Test Plan:
- Single request: requester 0 sends a = 3, b = -5 (0xFFFFFFFB) -> req_ready[0] pulses in cycle 0; rsp_valid[0] first high in cycle 19; rsp_r = 0xFFFFFFFFFFFFFFF1; rsp_err = 0.
- Fairness: all 4 requesters valid continuously, requester i sending a = i+1, b = 7, rsp_ready tied high -> grant order 0,1,2,3,0; products 7, 14, 21, 28; accepts spaced 20 cycles apart.
- Corner operands: a = b = 0x80000000 -> rsp_r = 0x4000000000000000. a = 0x7FFFFFFF, b = 0x80000000 -> rsp_r = 0xC000000080000000.
- Backpressure: rsp_ready[2] held low for 10 cycles after rsp_valid[2] while requester 1 is valid -> rsp_r stable throughout, req_ready[1] stays 0, grant to requester 1 occurs one cycle after the handshake.
- Timeout: multiplier model holds mul_ready low indefinitely after accept -> after 32 WAIT cycles rsp_valid is high with rsp_err = 1 and rsp_r = 0; the next request is served normally once the model is released.
- Reset mid-WAIT: assert sync_rst_n = 0 for 1 cycle in cycle 10 of an operation -> all outputs 0 the next cycle, no rsp_valid for that operation, rr_ptr = 0; a fresh request completes with the correct product.

Source files
------------

// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared types, widths and round-robin pick helper
// Contents: state_t FSM encoding, operand/product widths, rr_pick().
package mult_share_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int MUL_W   = 32;
  localparam int PROD_W  = 64;
  localparam int MAX_REQ = 8;

  // One-hot winner: first set bit of valid_vec at or after ptr, wrapping at n.
  // Bits at and above n are always zero in the result.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                                 input logic [2:0]         ptr,
                                                 input logic [3:0]         n);
    logic [MAX_REQ-1:0] pick;
    logic [3:0]         idx;
    pick = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      // ptr < n and k < n, so a single subtraction is enough to wrap
      idx = {1'b0, ptr} + k[3:0];
      if (idx >= n) idx = idx - n;
      if ((k[3:0] < n) && (pick == '0) && valid_vec[idx[2:0]]) pick[idx[2:0]] = 1'b1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// rtl/mult_share_arbiter_rr.sv - combinational round-robin picker
// Ports: valid  - request vector
//        ptr    - search start index (held by the parent)
//        grant  - one-hot winner or zero
//        grant_idx - binary index of the winner
//        any    - a winner exists
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [MAX_REQ-1:0] pick;

  always_comb begin
    pick      = rr_pick(MAX_REQ'(valid), 3'(ptr), 4'(NUM_REQ));
    grant     = pick[NUM_REQ-1:0];
    any       = |pick;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one 32x32 signed multiplier
// Ports: clk, sync_rst_n           - clock, synchronous active-low reset
//        req_valid/req_ready/req_a/req_b - per-requester operand channel
//        rsp_valid/rsp_ready       - per-requester response channel
//        rsp_r, rsp_err            - shared product and timeout flag
//        mul_valid/mul_a/mul_b     - issue side of the multiplier
//        mul_r, mul_ready          - multiplier result and ready/busy indication
//        busy, grant_id            - status: not IDLE, current/last owner
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     sync_rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MUL_W-1:0] req_a,
  input  logic [NUM_REQ*MUL_W-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [PROD_W-1:0]        rsp_r,
  output logic                     rsp_err,
  output logic                     mul_valid,
  output logic [MUL_W-1:0]         mul_a,
  output logic [MUL_W-1:0]         mul_b,
  input  logic [PROD_W-1:0]        mul_r,
  input  logic                     mul_ready,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_q;
  logic [MUL_W-1:0]   a_q, b_q;
  logic [TW-1:0]      tcnt;
  logic               seen_busy;
  logic [NUM_REQ-1:0] win;
  logic [ID_W-1:0]    win_idx;
  logic               win_any;
  logic [MUL_W-1:0]   win_a, win_b;
  logic               done, expired;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .grant     (win),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_a = req_a[i*MUL_W +: MUL_W];
        win_b = req_b[i*MUL_W +: MUL_W];
      end
    end
  end

  // A product is only trusted after the multiplier has shown busy at least once,
  // so the ready left over from the issue handshake is not mistaken for completion.
  assign done    = seen_busy && mul_ready;
  assign expired = !done && (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tcnt      <= '0;
      seen_busy <= 1'b0;
      rsp_r     <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (win_any) begin
            a_q    <= win_a;
            b_q    <= win_b;
            id_q   <= win_idx;
            rr_ptr <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        ISSUE: begin
          if (mul_ready) begin
            seen_busy <= 1'b0;
            tcnt      <= '0;
          end
        end
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (!mul_ready) seen_busy <= 1'b1;
          if (done) begin
            rsp_r   <= mul_r;
            rsp_err <= 1'b0;
          end else if (expired) begin
            rsp_r   <= '0;
            rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    mul_valid = 1'b0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        if (win_any) begin
          // a handshake during reset would be dropped, so never offer one
          req_ready = win & {NUM_REQ{sync_rst_n}};
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mul_valid = 1'b1;
        if (mul_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (done || expired) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = NUM_REQ'(1) << id_q;
        if (rsp_ready[id_q]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mul_a    = a_q;
  assign mul_b    = b_q;
  assign busy     = (state != IDLE);
  assign grant_id = id_q;

endmodule
